// File: rtl/pe_weight_loader.sv
// Weight loader for one PE: drains the PE, streams NUM_WORDS words onto its weight bus, gates i_valid until loaded.
// Optional running checksum of the loaded words is enabled by defining PE_WEIGHT_LOADER_CHECKSUM_EN.
module pe_weight_loader #(
    parameter logic [31:0] BASE_ADDR    = 32'd23,
    parameter int          NUM_WORDS    = 226,
    parameter int          DRAIN_CYCLES = 16,
    parameter int          CNT_WIDTH    = $clog2(NUM_WORDS + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] weight_wr_data,
    output logic [31:0] weight_wr_addr,
    output logic        weight_wr_en,
    input  logic        pe_ready,
    input  logic        pe_i_valid_in,
    output logic        pe_i_valid_out,
    output logic        busy,
    output logic        loaded,
    output logic        done,
    output logic [15:0] checksum
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0]   DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] WORD_LAST  = CNT_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [DRAIN_W-1:0]   drain_cnt_r;
    logic [CNT_WIDTH-1:0] word_cnt_r;
    logic                 handshake_s;
    logic                 last_word_s;
    logic                 load_req_s;
    logic                 wr_en_r;
    logic [31:0]          wr_addr_r;
    logic [15:0]          wr_data_r;
    logic                 loaded_r;
    logic                 done_r;

    assign s_ready     = (state_r == LOAD);
    assign handshake_s = s_valid & s_ready;
    assign last_word_s = handshake_s & (word_cnt_r == WORD_LAST);
    assign load_req_s  = (state_r == IDLE) & start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; start outside IDLE is deliberately ignored
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_nxt_s = DRAIN;
                else       state_nxt_s = IDLE;
            end
            DRAIN: begin
                if (pe_ready && (drain_cnt_r == DRAIN_LAST)) state_nxt_s = LOAD;
                else                                         state_nxt_s = DRAIN;
            end
            LOAD: begin
                if (last_word_s) state_nxt_s = IDLE;
                else             state_nxt_s = LOAD;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Drain counter: any low pe_ready cycle restarts the quiet-period count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt_r <= '0;
        end else if ((state_r == DRAIN) && pe_ready) begin
            drain_cnt_r <= drain_cnt_r + DRAIN_W'(1);
        end else begin
            drain_cnt_r <= '0;
        end
    end

    // Word counter: zero outside LOAD, so it starts cleared on every LOAD entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_r <= '0;
        end else if (state_r != LOAD) begin
            word_cnt_r <= '0;
        end else if (handshake_s) begin
            word_cnt_r <= word_cnt_r + CNT_WIDTH'(1);
        end else begin
            word_cnt_r <= word_cnt_r;
        end
    end

    // Weight write port: address/data hold between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= 32'd0;
            wr_data_r <= 16'd0;
        end else begin
            wr_en_r <= handshake_s;
            if (handshake_s) begin
                wr_addr_r <= BASE_ADDR + 32'(word_cnt_r);
                wr_data_r <= s_data;
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_data_r <= wr_data_r;
            end
        end
    end

    // Completion status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loaded_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= last_word_s;
            if (load_req_s) begin
                loaded_r <= 1'b0;
            end else if (last_word_s) begin
                loaded_r <= 1'b1;
            end else begin
                loaded_r <= loaded_r;
            end
        end
    end

`ifdef PE_WEIGHT_LOADER_CHECKSUM_EN
    logic [15:0] sum_r;

    // Running modulo-2^16 sum, updated in step with the weight write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r <= 16'd0;
        end else if (load_req_s) begin
            sum_r <= 16'd0;
        end else if (handshake_s) begin
            sum_r <= sum_r + s_data;
        end else begin
            sum_r <= sum_r;
        end
    end

    assign checksum = sum_r;
`else
    assign checksum = 16'd0;
`endif

    assign weight_wr_en   = wr_en_r;
    assign weight_wr_addr = wr_addr_r;
    assign weight_wr_data = wr_data_r;
    assign loaded         = loaded_r;
    assign done           = done_r;
    assign busy           = (state_r != IDLE);
    assign pe_i_valid_out = pe_i_valid_in & loaded_r;

endmodule

// File: tb/tb_pe_weight_loader.sv
// Bench for pe_weight_loader: random/directed word streams checked against an expected write list.
module tb_pe_weight_loader;

    localparam logic [31:0] BASE = 32'd23;
    localparam int NW    = 226;
    localparam int DC    = 16;
    localparam int LIMIT = 3000;

    logic        clk = 1'b0;
    logic        rst_n, start, s_valid, s_ready, pe_ready, pe_i_valid_in, pe_i_valid_out;
    logic [15:0] s_data, weight_wr_data, checksum;
    logic [31:0] weight_wr_addr;
    logic        weight_wr_en, busy, loaded, done;

    int vectors = 0;
    int errors  = 0;

    logic [15:0] wds [NW];
    logic [31:0] wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    int          wr_cyc_q  [$];
    int          cyc = 0;
    int          load_cyc = 0;
    int          done_cnt = 0;
    int          leak_cnt = 0;
    logic [31:0] done_addr = 32'd0;
    logic        done_wr = 1'b0;
    logic [15:0] done_sum = 16'd0;
    logic        prev_s_ready = 1'b0;

    pe_weight_loader #(.BASE_ADDR(BASE), .NUM_WORDS(NW), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .weight_wr_data(weight_wr_data), .weight_wr_addr(weight_wr_addr), .weight_wr_en(weight_wr_en),
        .pe_ready(pe_ready), .pe_i_valid_in(pe_i_valid_in), .pe_i_valid_out(pe_i_valid_out),
        .busy(busy), .loaded(loaded), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: records every write and done pulse for the tests to inspect
    always @(negedge clk) begin
        prev_s_ready <= s_ready;
        if (s_ready && !prev_s_ready) load_cyc <= cyc;
        if (weight_wr_en) begin
            wr_addr_q.push_back(weight_wr_addr);
            wr_data_q.push_back(weight_wr_data);
            wr_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_addr <= weight_wr_addr;
            done_wr   <= weight_wr_en;
            done_sum  <= checksum;
        end
        if (busy && pe_i_valid_out) leak_cnt <= leak_cnt + 1;
    end

    function automatic logic [15:0] exp_sum();
        logic [31:0] s;
        s = 32'd0;
`ifdef PE_WEIGHT_LOADER_CHECKSUM_EN
        for (int i = 0; i < NW; i++) s = s + 32'(wds[i]);
`endif
        return s[15:0];
    endfunction

    task automatic pulse_start(output int edge_no);
        @(negedge clk);
        start   = 1'b1;
        edge_no = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: continuous valid, 1: alternating, 2: random; inject adds start pulses during LOAD
    task automatic drive_stream(input int mode, input bit inject, input int stop_n);
        int   idx = 0;
        int   n = 0;
        logic v = 1'b0;
        while (idx < stop_n && n < LIMIT) begin
            @(negedge clk);
            n++;
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = ~v;
            else                v = 1'($urandom_range(0, 1));
            s_valid = v;
            s_data  = wds[idx];
            start   = 1'b0;
            if (inject && s_ready && ((idx == NW / 2) || (v && idx == NW - 1))) start = 1'b1;
            if (v && s_ready) idx++;
        end
        vectors++;
        if (idx < stop_n) begin
            errors++;
            $display("FAIL stream_timeout: accepted %0d words, required %0d", idx, stop_n);
        end
        @(negedge clk);
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 16'd0;
        pe_ready = 1'b1; pe_i_valid_in = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({s_ready, weight_wr_en, busy, loaded, done, pe_i_valid_out} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 000000", {s_ready, weight_wr_en, busy, loaded, done, pe_i_valid_out});
        end
        vectors++;
        if ({weight_wr_addr, weight_wr_data, checksum} !== 64'd0) begin
            errors++;
            $display("FAIL reset_bus: addr %0h data %0h sum %0h, expected all 0", weight_wr_addr, weight_wr_data, checksum);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, loaded, pe_i_valid_out, weight_wr_en} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b, expected 0000", {busy, loaded, pe_i_valid_out, weight_wr_en});
        end
    endtask

    task automatic test_full_load();
        int se, mark, dmark, lmark;
        for (int i = 0; i < NW; i++) wds[i] = 16'(i);
        mark = wr_addr_q.size(); dmark = done_cnt; lmark = leak_cnt;
        pulse_start(se);
        drive_stream(0, 1'b0, NW);
        repeat (2) @(negedge clk);
        #2;
        vectors++;
        if (load_cyc !== se + DC) begin
            errors++; $display("FAIL full_load_entry: edge %0d, expected %0d", load_cyc, se + DC);
        end
        vectors++;
        if (wr_cyc_q[mark] !== load_cyc + 1) begin
            errors++; $display("FAIL full_first_write: edge %0d, expected %0d", wr_cyc_q[mark], load_cyc + 1);
        end
        vectors++;
        if (wr_addr_q.size() - mark !== NW) begin
            errors++; $display("FAIL full_count: %0d writes, expected %0d", wr_addr_q.size() - mark, NW);
        end
        for (int i = 0; i < NW; i++) begin
            vectors++;
            if (wr_addr_q[mark+i] !== BASE + 32'(i) || wr_data_q[mark+i] !== wds[i]) begin
                errors++;
                $display("FAIL full_write[%0d]: addr %0d data %0d, expected addr %0d data %0d",
                         i, wr_addr_q[mark+i], wr_data_q[mark+i], BASE + 32'(i), wds[i]);
            end
        end
        vectors++;
        if (done_cnt - dmark !== 1 || done_addr !== BASE + 32'(NW - 1) || done_wr !== 1'b1) begin
            errors++;
            $display("FAIL full_done: pulses %0d addr %0d wr_en %b, expected 1 %0d 1", done_cnt - dmark, done_addr, done_wr, BASE + 32'(NW - 1));
        end
        vectors++;
        if (done_sum !== exp_sum() || checksum !== exp_sum()) begin
            errors++; $display("FAIL full_checksum: at done %0d now %0d, expected %0d", done_sum, checksum, exp_sum());
        end
        vectors++;
        if ({loaded, busy, pe_i_valid_out} !== 3'b101 || leak_cnt != lmark) begin
            errors++; $display("FAIL full_status: loaded/busy/ivalid %b leaks %0d, expected 101 0", {loaded, busy, pe_i_valid_out}, leak_cnt - lmark);
        end
        pe_i_valid_in = 1'b0;
        #1;
        vectors++;
        if (pe_i_valid_out !== 1'b0) begin
            errors++; $display("FAIL ivalid_gate_low: got %b, expected 0", pe_i_valid_out);
        end
        pe_i_valid_in = 1'b1;
    endtask

    task automatic test_bubbles();
        int se, mark, dmark, lmark;
        for (int i = 0; i < NW; i++) wds[i] = 16'($urandom);
        mark = wr_addr_q.size(); dmark = done_cnt; lmark = leak_cnt;
        pulse_start(se);
        drive_stream(1, 1'b0, NW);
        repeat (2) @(negedge clk);
        #2;
        vectors++;
        if (wr_addr_q.size() - mark !== NW) begin
            errors++; $display("FAIL bubble_count: %0d writes, expected %0d", wr_addr_q.size() - mark, NW);
        end
        for (int i = 0; i < NW; i++) begin
            vectors++;
            if (wr_addr_q[mark+i] !== BASE + 32'(i) || wr_data_q[mark+i] !== wds[i]) begin
                errors++;
                $display("FAIL bubble_write[%0d]: addr %0d data %0h, expected addr %0d data %0h",
                         i, wr_addr_q[mark+i], wr_data_q[mark+i], BASE + 32'(i), wds[i]);
            end
        end
        vectors++;
        if (done_cnt - dmark !== 1 || done_addr !== BASE + 32'(NW - 1) || done_wr !== 1'b1) begin
            errors++; $display("FAIL bubble_done: pulses %0d addr %0d, expected 1 %0d", done_cnt - dmark, done_addr, BASE + 32'(NW - 1));
        end
        vectors++;
        if (done_sum !== exp_sum() || leak_cnt != lmark) begin
            errors++; $display("FAIL bubble_sum_gate: sum %0h leaks %0d, expected %0h 0", done_sum, leak_cnt - lmark, exp_sum());
        end
    endtask

    task automatic test_drain_restart();
        int se, rise, mark;
        for (int i = 0; i < NW; i++) wds[i] = 16'($urandom);
        mark = wr_addr_q.size();
        pulse_start(se);
        repeat (6) @(negedge clk);
        pe_ready = 1'b0;
        repeat (5) @(negedge clk);
        pe_ready = 1'b1;
        rise = cyc + 1;
        drive_stream(2, 1'b0, NW);
        repeat (2) @(negedge clk);
        #2;
        vectors++;
        if (load_cyc !== rise + DC - 1) begin
            errors++; $display("FAIL drain_entry: edge %0d, expected %0d", load_cyc, rise + DC - 1);
        end
        vectors++;
        if (wr_cyc_q[mark] <= load_cyc) begin
            errors++; $display("FAIL drain_early_write: first write edge %0d, expected > %0d", wr_cyc_q[mark], load_cyc);
        end
        vectors++;
        if (wr_addr_q.size() - mark !== NW || wr_addr_q[mark+NW-1] !== BASE + 32'(NW - 1) || wr_data_q[mark+NW-1] !== wds[NW-1]) begin
            errors++; $display("FAIL drain_load: %0d writes last addr %0d, expected %0d %0d", wr_addr_q.size() - mark, wr_addr_q[mark+NW-1], NW, BASE + 32'(NW - 1));
        end
    endtask

    task automatic test_back_to_back();
        int se, mark, dmark;
        for (int i = 0; i < NW; i++) wds[i] = 16'($urandom);
        mark = wr_addr_q.size(); dmark = done_cnt;
        pulse_start(se);
        drive_stream(2, 1'b1, NW);
        repeat (40) @(negedge clk);
        #2;
        vectors++;
        if (wr_addr_q.size() - mark !== NW || done_cnt - dmark !== 1) begin
            errors++; $display("FAIL b2b_count: %0d writes %0d dones, expected %0d 1", wr_addr_q.size() - mark, done_cnt - dmark, NW);
        end
        vectors++;
        if ({busy, loaded, s_ready} !== 3'b010) begin
            errors++; $display("FAIL b2b_state: busy/loaded/s_ready %b, expected 010", {busy, loaded, s_ready});
        end
        vectors++;
        if (done_sum !== exp_sum()) begin
            errors++; $display("FAIL b2b_checksum: got %0h, expected %0h", done_sum, exp_sum());
        end
    endtask

    task automatic test_reset_midload();
        int se, mark, dmark;
        for (int i = 0; i < NW; i++) wds[i] = 16'($urandom);
        mark = wr_addr_q.size();
        pulse_start(se);
        drive_stream(0, 1'b0, 100);
        #2;
        vectors++;
        if (wr_addr_q.size() - mark !== 100) begin
            errors++; $display("FAIL midload_count: %0d writes, expected 100", wr_addr_q.size() - mark);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({s_ready, weight_wr_en, busy, loaded, done, pe_i_valid_out} !== 6'b0) begin
            errors++; $display("FAIL midload_reset_flags: got %b, expected 000000", {s_ready, weight_wr_en, busy, loaded, done, pe_i_valid_out});
        end
        vectors++;
        if ({weight_wr_addr, weight_wr_data, checksum} !== 64'd0) begin
            errors++; $display("FAIL midload_reset_bus: addr %0h data %0h sum %0h, expected 0", weight_wr_addr, weight_wr_data, checksum);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        mark = wr_addr_q.size(); dmark = done_cnt;
        pulse_start(se);
        drive_stream(0, 1'b0, NW);
        repeat (2) @(negedge clk);
        #2;
        vectors++;
        if (wr_addr_q[mark] !== BASE || wr_addr_q.size() - mark !== NW || done_cnt - dmark !== 1) begin
            errors++;
            $display("FAIL reload: first addr %0d writes %0d dones %0d, expected %0d %0d 1", wr_addr_q[mark], wr_addr_q.size() - mark, done_cnt - dmark, BASE, NW);
        end
        vectors++;
        if (wr_data_q[mark+NW-1] !== wds[NW-1] || loaded !== 1'b1 || done_sum !== exp_sum()) begin
            errors++; $display("FAIL reload_final: data %0h loaded %b sum %0h, expected %0h 1 %0h", wr_data_q[mark+NW-1], loaded, done_sum, wds[NW-1], exp_sum());
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_bubbles();
        test_drain_restart();
        test_back_to_back();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 2 ms");
        $fatal(1);
    end

endmodule

// File: doc/pe_weight_loader.md
Name: pe_weight_loader

Overview:
- Sequences loading of one PE's weight address map (kernel, bias, MACC coefficient, layer scale) from a valid/ready word stream onto the PE's weight_wr_* bus.
- Drains the PE before any reload and gates the PE's i_valid until a complete weight set is resident.
- Sits between the top-level weight DMA stream and a single PE instance; one loader per PE.

Parameters:
- BASE_ADDR, 23, first weight address of the target PE (its kernel base).
- NUM_WORDS, 226, words in the PE map (3*3*3*8 kernel + 8 bias + 1 MACC coeff + 1 layer scale). Must be >= 1.
- DRAIN_CYCLES, 16, consecutive cycles with pe_ready high required before writing. Must be >= PE pipeline depth.
- CNT_WIDTH, $clog2(NUM_WORDS+1), width of the word counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- start  in  1  single-cycle pulse requesting a (re)load
- s_data  in  16  weight word stream data
- s_valid  in  1  stream valid
- s_ready  out  1  stream ready
- weight_wr_data  out  16  to PE weight_wr_data
- weight_wr_addr  out  32  to PE weight_wr_addr
- weight_wr_en  out  1  to PE weight_wr_en
- pe_ready  in  1  PE controller ready (PE idle)
- pe_i_valid_in  in  1  upstream i_valid destined for the PE
- pe_i_valid_out  out  1  gated i_valid to the PE
- busy  out  1  high in any state other than IDLE
- loaded  out  1  level: complete weight set resident
- done  out  1  one-cycle pulse at load completion
- checksum  out  16  modular sum of the loaded words (see Optional Feature)

Behaviour:
- Reset values: s_ready=0, weight_wr_en=0, weight_wr_addr=0, weight_wr_data=0, busy=0, loaded=0, done=0, checksum=0, state=IDLE, counters=0.
- States: IDLE, DRAIN, LOAD.
- IDLE:
  - start=1 -> DRAIN; loaded cleared on the next cycle; drain counter cleared.
  - start in any other state is ignored.
- DRAIN:
  - pe_ready=1 increments the drain counter; pe_ready=0 resets it to 0.
  - When the counter reaches DRAIN_CYCLES-1 with pe_ready=1 -> LOAD; word counter cleared.
- LOAD:
  - s_ready = (state==LOAD); combinational from the state register.
  - Each handshake (s_valid & s_ready) at cycle t produces, at t+1: weight_wr_en=1, weight_wr_addr=BASE_ADDR+cnt, weight_wr_data=s_data. The word counter then increments.
  - Bubbles in s_valid produce weight_wr_en=0 cycles; the address does not advance.
  - Handshake on word NUM_WORDS-1 -> IDLE. At t+1: last write, done=1, loaded=1, s_ready=0. No further word is accepted.
- weight_wr_addr/data hold their last value when weight_wr_en=0.
- pe_i_valid_out = pe_i_valid_in & loaded, combinational.
  - Upstream must hold data; a dropped i_valid is the upstream's responsibility.
  - loaded=0 from the cycle after start until done.
- Address arithmetic is 32-bit unsigned with no wrap; BASE_ADDR+NUM_WORDS-1 < 2^32.
- Reset mid-load: everything returns to reset values immediately (async). The partial weight set is invalid and loaded=0.
- start and the final handshake in the same cycle: start is ignored (state is LOAD).

Optional Feature:
- Macro: PE_WEIGHT_LOADER_CHECKSUM_EN.
- Defined:
  - checksum cleared on entry to DRAIN.
  - Each accepted word is added modulo 2^16 at the same cycle weight_wr_en is asserted.
  - The final value is valid while done=1 and holds until the next start.
- Undefined: checksum tied to 0, no adder inferred.

Test Plan:
- Reset, no stimulus -> all outputs 0; pe_i_valid_in=1 gives pe_i_valid_out=0.
- start, pe_ready=1 constant, s_valid=1 continuous, data=word index -> LOAD entered 16 cycles after start; 226 writes at addrs 23..248, data 0..225; done pulse with the write to 248; loaded=1; checksum=25425 with macro, 0 without.
- Same as previous scenario, but s_valid toggles 1/0 every cycle -> 226 writes, no gaps in the address sequence, no duplicates; done on the last write only.
- pe_ready low for 5 cycles mid-DRAIN -> drain counter restarts; LOAD entered 16 cycles after pe_ready last rises; no weight_wr_en before that.
- Second start pulse during LOAD, plus start coincident with the final handshake -> both ignored; exactly 226 writes; single done pulse.
- rst_n asserted after 100 writes, then released and start issued -> outputs reset, loaded=0; the new load restarts at addr 23 and completes with 226 writes.
